// File: rtl/simple_processor_pkg.sv
// Shared types, widths and decode helpers for the shift-processor pipeline.
package simple_processor_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;
    localparam int IMM_WIDTH      = 6;

    typedef enum logic [3:0] {
        SLL  = 4'h0,
        SLLI = 4'h1,
        SLR  = 4'h2,
        SLRI = 4'h3
    } func_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ofs_state_t;

    // Only the immediate forms ignore rs2; unknown opcodes are treated as using it.
    function automatic logic uses_rs2(input logic [3:0] func);
        return !((func == 4'(SLLI)) || (func == 4'(SLRI)));
    endfunction

endpackage

// File: rtl/operand_fetch_stage_reg_file.sv
// Register file: two combinational read ports with write-through, one write port, x0 fixed at zero.
module reg_file
    import simple_processor_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = REG_ADDR_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr1_i,
    output logic [DW-1:0] rdata1_o,
    input  logic [AW-1:0] raddr2_i,
    output logic [DW-1:0] rdata2_o
);

    localparam int N = 2 ** AW;

    logic [DW-1:0] regs [N];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    // A same-cycle write to the read address is forwarded so the reader sees the new value.
    assign rdata1_o = (raddr1_i == '0) ? '0 :
                      (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 :
                      (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs[raddr2_i];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch for the shift ALU: register read, immediate extension,
// pending-write scoreboard hazard stall and a one-entry output register.
module operand_fetch_stage
    import simple_processor_pkg::*;
#(
    parameter int DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = simple_processor_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [3:0]                func_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic [5:0]                imm_i,
    input  logic                      wb_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    output logic                      ex_valid_o,
    input  logic                      ex_ready_i,
    output logic [3:0]                ex_func_o,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_o,
    output logic [DATA_WIDTH-1:0]     rs1_data_o,
    output logic [DATA_WIDTH-1:0]     rs2_data_o,
    output logic [DATA_WIDTH-1:0]     imm_o,
    output ofs_state_t                state_o
);

    localparam int NREGS = 2 ** REG_ADDR_WIDTH;

    // Handshake: a transfer happens on a clock edge where valid and ready are both high,
    // on either side. ready_o never looks at valid_i; ex_* hold stable while ex_valid_o
    // is high and ex_ready_i is low.

    ofs_state_t                state_q, state_d;
    logic [NREGS-1:0]          pend_q, pend_d;
    logic [DATA_WIDTH-1:0]     rd1_data, rd2_data;
    logic                      rs1_haz, rs2_haz, waw_haz, hazard, issue;

    reg_file #(
        .DW (DATA_WIDTH),
        .AW (REG_ADDR_WIDTH)
    ) u_reg_file (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (wb_en_i),
        .waddr_i  (wb_addr_i),
        .wdata_i  (wb_data_i),
        .raddr1_i (rs1_addr_i),
        .rdata1_o (rd1_data),
        .raddr2_i (rs2_addr_i),
        .rdata2_o (rd2_data)
    );

    // A source being written back this cycle is satisfied by the bypass; a destination is not.
    always_comb begin
        rs1_haz = (rs1_addr_i != '0) && pend_q[rs1_addr_i] &&
                  !(wb_en_i && (wb_addr_i == rs1_addr_i));
        rs2_haz = uses_rs2(func_i) && (rs2_addr_i != '0) && pend_q[rs2_addr_i] &&
                  !(wb_en_i && (wb_addr_i == rs2_addr_i));
        waw_haz = (rd_addr_i != '0) && pend_q[rd_addr_i];
        hazard  = rs1_haz || rs2_haz || waw_haz;
        ready_o = !hazard && ((state_q == ST_EMPTY) || ex_ready_i);
        issue   = valid_i && ready_o;
    end

    always_comb begin
        pend_d = pend_q;
        if (wb_en_i && (wb_addr_i != '0)) begin
            pend_d[wb_addr_i] = 1'b0;
        end
        if (issue && (rd_addr_i != '0)) begin
            pend_d[rd_addr_i] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (issue) state_d = ST_FULL;
            ST_FULL:  if (!issue && ex_ready_i) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_func_o    <= '0;
            ex_rd_addr_o <= '0;
            rs1_data_o   <= '0;
            rs2_data_o   <= '0;
            imm_o        <= '0;
        end else if (issue) begin
            ex_func_o    <= func_i;
            ex_rd_addr_o <= rd_addr_i;
            rs1_data_o   <= rd1_data;
            rs2_data_o   <= uses_rs2(func_i) ? rd2_data : '0;
            imm_o        <= {{(DATA_WIDTH-6){imm_i[5]}}, imm_i};
        end
    end

    assign ex_valid_o = (state_q == ST_FULL);
    assign state_o    = state_q;

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Stage directly upstream of the shift ALU. It accepts decoded shift instructions over a valid/ready handshake and reads the 32-entry register file.
- Sign-extends the 6-bit immediate to DATA_WIDTH. Stalls on register hazards using a pending-write scoreboard.
- Presents registered rs1_data/rs2_data/imm/func to the ALU. Absorbs writeback from the stage after the ALU, with same-cycle bypass.

Parameters:
- DATA_WIDTH, 32, operand/result width (from simple_processor_pkg)
- REG_ADDR_WIDTH, 5, register index width; NUM_REGS = 2**REG_ADDR_WIDTH

Ports:
- clk_i  in  1  clock, all state updates on posedge
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  decoded instruction valid
- ready_o  out  1  stage accepts instruction this cycle
- func_i  in  4  func_t opcode
- rd_addr_i  in  REG_ADDR_WIDTH  destination register
- rs1_addr_i  in  REG_ADDR_WIDTH  source 1
- rs2_addr_i  in  REG_ADDR_WIDTH  source 2; ignored for SLLI/SLRI
- imm_i  in  6  raw immediate
- wb_en_i  in  1  writeback strobe
- wb_addr_i  in  REG_ADDR_WIDTH  writeback register
- wb_data_i  in  DATA_WIDTH  writeback data
- ex_valid_o  out  1  operands valid to ALU
- ex_ready_i  in  1  ALU consumes this cycle
- ex_func_o  out  4  registered func
- ex_rd_addr_o  out  REG_ADDR_WIDTH  registered destination
- rs1_data_o  out  DATA_WIDTH  registered operand 1
- rs2_data_o  out  DATA_WIDTH  registered operand 2; 0 for immediate forms
- imm_o  out  DATA_WIDTH  sign-extended immediate {{DATA_WIDTH-6{imm_i[5]}}, imm_i}

Behaviour:
- Reset, sampled on posedge with rst_i=1:
  - all registers and the scoreboard clear to 0
  - ex_valid_o=0; ex_func_o, ex_rd_addr_o, rs1_data_o, rs2_data_o and imm_o = 0
  - reset mid-operation discards the held instruction and all pending bits; writebacks in that cycle are dropped
- Register file:
  - x0 reads 0 at all times; writes to x0 are ignored
  - synchronous write on wb_en_i
  - combinational read with write-through: if wb_en_i and wb_addr_i equals the read address (nonzero), the read returns wb_data_i
- Scoreboard: one pending bit per register.
  - Set on issue for rd_addr_i != 0.
  - Cleared when wb_en_i hits that address.
  - Set and clear on the same address in the same cycle: set wins.
- Output register is a one-entry state machine with states EMPTY (ex_valid_o=0) and FULL (ex_valid_o=1).
- hazard = a used source (rs1 always; rs2 only for SLL/SLR) is nonzero, pending, and not being written back this cycle; OR rd_addr_i != 0 and pending (WAW; a same-cycle clear of rd does not lift it).
- ready_o = !hazard && (!ex_valid_o || ex_ready_i). Combinational; no dependence on valid_i.
- Issue happens when valid_i && ready_o. The output register loads on the next edge; latency is 1 cycle from accept to ex_valid_o.
- FULL && ex_ready_i && no issue -> EMPTY. FULL && ex_ready_i && issue -> FULL, with back-to-back new data.
- While FULL and !ex_ready_i, all ex_* outputs hold stable.
- Invalid func codes are accepted and passed through unchanged; rs2 is treated as used for them.

Decomposition:
- In simple_processor_pkg:
  - func_t enum: SLL=4'h0, SLLI=4'h1, SLR=4'h2, SLRI=4'h3
  - REG_ADDR_WIDTH, NUM_REGS
  - uses_rs2(func) function
- One sub-module, reg_file: 2 read ports, 1 write port, x0 hardwired to zero, write-through bypass.
- Scoreboard, hazard logic and output register live in operand_fetch_stage.

Test Plan:
- Reset then wb x5=0x0000_00F0, then issue SLL rd=6 rs1=5 rs2=0 -> next cycle ex_valid_o=1, rs1_data_o=0xF0, rs2_data_o=0, ex_rd_addr_o=6.
- SLLI imm_i=6'b111100 -> imm_o=0xFFFF_FFFC; imm_i=6'b011111 -> imm_o=0x0000_001F; rs2_data_o=0.
- Issue SLR rd=7, then SLL rs1=7 -> ready_o=0 until wb_en_i x7=0x1234. In that wb cycle ready_o=1 and rs1_data_o captures 0x1234 by bypass.
- Issue SLLI rd=8 with x8 pending -> WAW stall. SLLI rd=0 with x0 "pending" never stalls; wb to x0 leaves reads at 0.
- Hold ex_ready_i=0 for 5 cycles with valid_i=1 -> outputs stable and ready_o=0. Then raise ex_ready_i: one-per-cycle throughput resumes with no drop or duplicate.
- Assert rst_i while FULL with x3 pending -> next cycle ex_valid_o=0, ready_o=1, x3 not pending, all registers read 0.
